// File: rtl/cls_add_seq.sv
// Multi-word adder/subtractor that pushes one 16-bit slice per cycle through
// a single reused carry-select adder, with valid/ready handshakes on both sides.

module cls_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);

    // Four 4-bit blocks: each computes both carry-in cases and the incoming carry picks one
    always_comb begin
        logic       c;
        logic [4:0] s0;
        logic [4:0] s1;
        c     = cin_i;
        s0    = '0;
        s1    = '0;
        sum_o = '0;
        for (int k = 0; k < 4; k++) begin
            s0 = {1'b0, a_i[k*4 +: 4]} + {1'b0, b_i[k*4 +: 4]};
            s1 = s0 + 5'd1;
            sum_o[k*4 +: 4] = c ? s1[3:0] : s0[3:0];
            c = c ? s1[4] : s0[4];
        end
        cout_o = c;
    end

endmodule

module cls_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op_sub,
    input  logic [16*WORDS-1:0]   a,
    input  logic [16*WORDS-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   result,
    output logic                  carry_out,
    output logic                  overflow
);

    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic            carry_q, carry_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic [15:0]     sliceA;
    logic [15:0]     sliceB;
    logic [15:0]     sliceSum;
    logic            sliceCout;

    // b_q already holds the inverted operand for subtraction
    assign sliceA = a_q[{idx_q, 4'b0000} +: 16];
    assign sliceB = b_q[{idx_q, 4'b0000} +: 16];

    cls_16bit u_adder (
        .a_i    (sliceA),
        .b_i    (sliceB),
        .cin_i  (carry_q),
        .sum_o  (sliceSum),
        .cout_o (sliceCout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {W{op_sub}};
                    carry_d = op_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[{idx_q, 4'b0000} +: 16] = sliceSum;
                carry_d = sliceCout;
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(WORDS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand registers are only rewritten at accept, so these stay stable in DONE
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = (a_q[W-1] == b_q[W-1]) && (result_q[W-1] != a_q[W-1]);

endmodule

// File: tb/tb_cls_add_seq.sv
// Randomized and directed bench for cls_add_seq (WORDS=4), checked against a
// plain-arithmetic reference model.

module tb_cls_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          op_sub;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          carry_out;
    logic          overflow;

    int checkCount = 0;
    int errCount   = 0;

    cls_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference: exact arithmetic on widened unsigned and signed values
    task automatic model(input logic [W-1:0] aIn, input logic [W-1:0] bIn, input logic subIn,
                         output logic [W-1:0] expRes, output logic expCarry, output logic expOvf);
        logic [W:0]          uSum;
        logic signed [W+1:0] exact;
        logic signed [W+1:0] sa;
        logic signed [W+1:0] sb;
        logic signed [W+1:0] maxS;
        logic signed [W+1:0] minS;
        sa   = {{2{aIn[W-1]}}, aIn};
        sb   = {{2{bIn[W-1]}}, bIn};
        maxS = (66'sd1 <<< (W - 1)) - 66'sd1;
        minS = -(66'sd1 <<< (W - 1));
        if (subIn) begin
            uSum  = {1'b0, aIn} + {1'b0, ~bIn} + {{W{1'b0}}, 1'b1};
            exact = sa - sb;
        end else begin
            uSum  = {1'b0, aIn} + {1'b0, bIn};
            exact = sa + sb;
        end
        expRes   = uSum[W-1:0];
        expCarry = uSum[W];
        expOvf   = (exact > maxS) || (exact < minS);
    endtask

    task automatic applyStimulus(input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                                 input logic subIn, input int stall);
        logic [W-1:0] expRes;
        logic         expCarry;
        logic         expOvf;
        int           lat;
        int           waitCnt;
        logic         heldValid;
        model(aIn, bIn, subIn, expRes, expCarry, expOvf);
        waitCnt = 0;
        while (!in_ready && waitCnt < 20) begin
            @(posedge clk);
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("in_ready_before_accept", W'(in_ready), W'(1));
        in_valid = 1'b1;
        a        = aIn;
        b        = bIn;
        op_sub   = subIn;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        op_sub   = 1'($urandom);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        checkOutput("latency", W'(lat), W'(WORDS));
        checkOutput("result", result, expRes);
        checkOutput("carry_out", W'(carry_out), W'(expCarry));
        checkOutput("overflow", W'(overflow), W'(expOvf));
        heldValid = 1'b1;
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom);
            a        = {$urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            if (!out_valid || in_ready) heldValid = 1'b0;
        end
        in_valid = 1'b0;
        if (stall > 0) begin
            checkOutput("held_valid", W'(heldValid), W'(1));
            checkOutput("held_result", result, expRes);
            checkOutput("held_carry", W'(carry_out), W'(expCarry));
            checkOutput("held_overflow", W'(overflow), W'(expOvf));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("valid_drop", W'(out_valid), W'(0));
        checkOutput("ready_back", W'(in_ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_sub    = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        #12;
        checkOutput("reset_in_ready", W'(in_ready), W'(1));
        checkOutput("reset_out_valid", W'(out_valid), W'(0));
        checkOutput("reset_result", result, '0);
        checkOutput("reset_carry", W'(carry_out), W'(0));
        checkOutput("reset_overflow", W'(overflow), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed cases");
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
        applyStimulus(64'd5, 64'd7, 1'b1, 0);
        applyStimulus(64'd7, 64'd5, 1'b1, 0);
        applyStimulus(64'h8000_0000_0000_0000, 64'd1, 1'b1, 10);

        $display("[TB] reset during RUN");
        in_valid = 1'b1;
        a        = 64'h1234_5678_9ABC_DEF0;
        b        = 64'h0FED_CBA9_8765_4321;
        op_sub   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_in_ready", W'(in_ready), W'(1));
        checkOutput("midrun_out_valid", W'(out_valid), W'(0));
        checkOutput("midrun_result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(64'd3, 64'd4, 1'b0, 0);

        $display("[TB] random regression");
        for (int n = 0; n < 1000; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: ra = '1;
                1: rb = '1;
                2: ra = {1'b0, {(W-1){1'b1}}};
                3: rb = {1'b1, {(W-1){1'b0}}};
                default: ;
            endcase
            applyStimulus(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
        $finish;
    end

endmodule
